// File: rtl/branch_predictor.sv
// branch_predictor
//
// Branch target buffer with per-entry saturating direction counters. It sits
// beside the fetch stage and produces a predicted next PC combinationally in
// the same cycle as the fetch. The decode stage trains it with resolved
// branches. Two saturating performance counters track lookups and
// mispredictions.
//
// PCs are halfword aligned:
//   index = pc[IDX_W:1]
//   tag   = pc[ADDR_W-1:IDX_W+1]
//   pc[0] is ignored.
//
// Ports
//   clk                in   clock, rising edge
//   rst_n              in   synchronous active-low reset
//   lookup_valid       in   fetch presents lookup_pc this cycle
//   lookup_pc          in   PC being fetched
//   pred_hit           out  a valid entry matches lookup_pc
//   pred_taken         out  prediction is taken
//   pred_target        out  predicted next PC
//   update_valid       in   resolved branch reported this cycle
//   update_pc          in   PC of the resolved branch
//   update_taken       in   actual outcome
//   update_target      in   actual target
//   update_mispredict  in   earlier prediction for this branch was wrong
//   clear              in   invalidate all entries (update dropped)
//   lookup_cnt         out  saturating count of lookup_valid cycles
//   mispred_cnt        out  saturating count of mispredicting updates
module branch_predictor #(
    parameter int ADDR_W  = 16,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lookup_valid,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_valid,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic              update_taken,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_mispredict,
    input  logic              clear,
    output logic [PERF_W-1:0] lookup_cnt,
    output logic [PERF_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 1;

    // Allocation starts weakly taken; reset leaves counters weakly not-taken.
    localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
    localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};

    function automatic logic [CTR_W-1:0] ctr_sat_inc(input logic [CTR_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [CTR_W-1:0] ctr_sat_dec(input logic [CTR_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

    function automatic logic [PERF_W-1:0] perf_sat_inc(input logic [PERF_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [CTR_W-1:0]   r_ctr    [ENTRIES];
    logic [PERF_W-1:0]  r_lookup_cnt;
    logic [PERF_W-1:0]  r_mispred_cnt;

    logic [IDX_W-1:0]   w_lk_idx;
    logic [TAG_W-1:0]   w_lk_tag;
    logic [IDX_W-1:0]   w_up_idx;
    logic [TAG_W-1:0]   w_up_tag;
    logic               w_up_hit;
    logic               w_up_apply;
    logic               w_unused;

    assign w_lk_idx = lookup_pc[IDX_W:1];
    assign w_lk_tag = lookup_pc[ADDR_W-1:IDX_W+1];
    assign w_up_idx = update_pc[IDX_W:1];
    assign w_up_tag = update_pc[ADDR_W-1:IDX_W+1];
    assign w_unused = update_pc[0];

    // Lookup reads the registered table only, so a same-cycle update is not
    // bypassed and the lookup sees pre-update state.
    assign pred_hit    = lookup_valid & r_valid[w_lk_idx] & (r_tag[w_lk_idx] == w_lk_tag);
    assign pred_taken  = pred_hit & r_ctr[w_lk_idx][CTR_W-1];
    assign pred_target = pred_taken ? r_target[w_lk_idx] : lookup_pc + ADDR_W'(2);

    assign w_up_hit   = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);
    // clear outranks update, so an update in a clear cycle is dropped.
    assign w_up_apply = update_valid & ~clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_WNT;
            end
        end else if (clear) begin
            r_valid <= '0;
        end else if (update_valid) begin
            if (w_up_hit) begin
                r_ctr[w_up_idx] <= update_taken ? ctr_sat_inc(r_ctr[w_up_idx])
                                                : ctr_sat_dec(r_ctr[w_up_idx]);
            end else if (update_taken) begin
                r_valid[w_up_idx] <= 1'b1;
                r_ctr[w_up_idx]   <= CTR_WT;
            end
        end
    end

    // Tag/target carry no reset. A taken update writes both: on a hit the tag
    // is unchanged, on a miss it is the allocation.
    always_ff @(posedge clk) begin
        if (rst_n && w_up_apply && update_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= update_target;
        end
    end

    // Performance counters keep counting through clear cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lookup_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (lookup_valid) begin
                r_lookup_cnt <= perf_sat_inc(r_lookup_cnt);
            end
            if (update_valid && update_mispredict) begin
                r_mispred_cnt <= perf_sat_inc(r_mispred_cnt);
            end
        end
    end

    assign lookup_cnt  = r_lookup_cnt;
    assign mispred_cnt = r_mispred_cnt;

endmodule
